// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared state encoding and config address map for pulse_seq
package pulse_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] ADDR_PERIOD = 4'd0;
   localparam logic [3:0] ADDR_SLOT0  = 4'd1;

   // Config address of compare slot idx.
   function automatic logic [3:0] slot_addr(input int idx);
      return ADDR_SLOT0 + 4'(idx);
   endfunction

endpackage

// File: rtl/pulse_seq_slot.sv
// rtl/pulse_seq_slot.sv - one compare slot: value/enable register and match decode
module pulse_seq_slot
   import pulse_seq_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [CNT_W:0]   wdata,
   input  state_t           state,
   input  logic [CNT_W-1:0] cnt,
   output logic             match
);

   logic [CNT_W-1:0] cmp_q;
   logic             en_q;

   // Compare register; the top only raises wr while the sequencer is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_q <= '0;
         en_q  <= 1'b0;
      end else if (wr) begin
         cmp_q <= wdata[CNT_W-1:0];
         en_q  <= wdata[CNT_W];
      end
   end

   // Match straight off registered state and count; a cmp above period never
   // matches because the count never passes period.
   always_comb begin
      match = (state == RUN) && en_q && (cnt == cmp_q);
   end

endmodule

// File: rtl/pulse_seq.sv
// rtl/pulse_seq.sv - programmable pulse sequencer; PULSE_SEQ_PERIOD_CNT_EN adds period_cnt
module pulse_seq
   import pulse_seq_pkg::*;
#(
   parameter int CNT_W  = 4,
   parameter int N_SLOT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [CNT_W:0]    cfg_wdata,
   input  logic              start,
   input  logic              stop,
   input  logic              oneshot,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  cnt,
   output logic [N_SLOT-1:0] ctrl_vec,
   output logic              ctrl
`ifdef PULSE_SEQ_PERIOD_CNT_EN
   ,
   output logic [15:0]       period_cnt
`endif
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [CNT_W-1:0] period_q;
   logic             oneshot_q, oneshot_nxt;
   logic             accept;
   logic             period_end;
   logic             cfg_ok;

   // State, count and latched mode registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt_q     <= '0;
         oneshot_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt_q     <= cnt_nxt;
         oneshot_q <= oneshot_nxt;
      end
   end

   // Next state: stop beats both start and period end; start only counts in IDLE.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt_q;
      oneshot_nxt = oneshot_q;
      accept      = 1'b0;
      period_end  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_nxt   = RUN;
               cnt_nxt     = '0;
               oneshot_nxt = oneshot;
               accept      = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt_q == period_q) begin
               period_end = 1'b1;
               cnt_nxt    = '0;
               if (oneshot_q) begin
                  state_nxt = DONE;
               end
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Config is frozen outside IDLE so a running sequence never sees a partial update.
   always_comb begin
      cfg_ok = cfg_we && (state == IDLE);
   end

   // Period register; the enable bit of the write data has no meaning here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q <= '1;
      end else if (cfg_ok && (cfg_addr == ADDR_PERIOD)) begin
         period_q <= cfg_wdata[CNT_W-1:0];
      end
   end

   // Addresses beyond the last slot decode to no slot and are dropped.
   for (genvar i = 0; i < N_SLOT; i++) begin : g_slot
      pulse_seq_slot #(
         .CNT_W (CNT_W)
      ) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .wr    (cfg_ok && (cfg_addr == slot_addr(i))),
         .wdata (cfg_wdata),
         .state (state),
         .cnt   (cnt_q),
         .match (ctrl_vec[i])
      );
   end

   // Status outputs decode registered state only, so reset clears them at once.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
      cnt  = cnt_q;
      ctrl = |ctrl_vec;
   end

`ifdef PULSE_SEQ_PERIOD_CNT_EN
   logic [15:0] pcnt_q;

   // Completed-period counter: cleared by an accepted start, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else if (accept) begin
         pcnt_q <= '0;
      end else if (period_end && (pcnt_q != 16'hFFFF)) begin
         pcnt_q <= pcnt_q + 16'd1;
      end
   end

   always_comb begin
      period_cnt = pcnt_q;
   end
`endif

endmodule

// File: doc/pulse_seq.md
PULSE_SEQ -- requirements
Module: pulse_seq

Interface
REQ-001 Parameter CNT_W, default 4, sets the counter and compare width.
REQ-002 Parameter N_SLOT, default 2, sets the number of compare slots (1..8).
REQ-003 Clock and reset: clk input 1 is the single clock; rst_n input 1 is the asynchronous, active-low reset.
REQ-004 cfg_we  input  1  config write strobe.
REQ-005 cfg_addr  input  4  config address; 0 = period, 1..N_SLOT = slot i-1.
REQ-006 cfg_wdata  input  CNT_W+1  write data; bit CNT_W = slot enable, bits CNT_W-1:0 = value.
REQ-007 start  input  1  level-sampled start request.
REQ-008 stop  input  1  level-sampled abort request.
REQ-009 oneshot  input  1  sampled on accepted start; 1 = single period, 0 = continuous.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  one-cycle pulse at oneshot completion.
REQ-012 cnt  output  CNT_W  current count.
REQ-013 ctrl_vec  output  N_SLOT  per-slot match pulses.
REQ-014 ctrl  output  1  OR of ctrl_vec.

Function
REQ-015 The FSM shall have exactly the states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 with stop=0 shall enter RUN next cycle with cnt=0 and latch oneshot.
REQ-017 In RUN, cnt shall increment by 1 per cycle until cnt==period.
- At cnt==period in continuous mode, cnt shall wrap to 0.
- At cnt==period in oneshot mode, the FSM shall enter DONE.
REQ-018 DONE shall last one cycle with done=1, cnt=0, then return to IDLE.
REQ-019 stop=1 in RUN shall return to IDLE next cycle with cnt=0 and no done pulse; stop wins over start and over period end in the same cycle.
REQ-020 start while RUN or DONE shall be ignored.
REQ-021 ctrl_vec[i] shall equal (state==RUN && slot i enabled && cnt==cmp[i]), decoded from registered state and cnt with zero added latency.
REQ-022 A slot with cmp > period shall never fire; period=0 shall make cnt hold at 0 with every enabled cmp==0 slot firing every cycle.
REQ-023 Multiple slots with equal cmp shall fire together; ctrl shall be a single pulse.
REQ-024 Config writes shall take effect only in IDLE; writes in RUN or DONE shall be dropped silently.
REQ-025 cfg_addr > N_SLOT shall be ignored; a period write shall ignore bit CNT_W.
REQ-026 Arithmetic is unsigned CNT_W-bit; cnt shall never exceed period.

Reset
REQ-027 rst_n low shall asynchronously force state=IDLE, cnt=0, busy=0, done=0, ctrl=0, ctrl_vec=0.
REQ-028 Reset shall set period to all ones and every slot to value 0, disabled.
REQ-029 Reset asserted mid-RUN shall abort with no done pulse; the first cycle after deassertion is IDLE.

Configuration
REQ-030 Macro PULSE_SEQ_PERIOD_CNT_EN, when defined, shall add output period_cnt [15:0].
- period_cnt is cleared on accepted start.
- It increments at each completed period, including the oneshot completion.
- It saturates at 0xFFFF and holds its value in IDLE.
- It is reset to 0.
REQ-031 Without PULSE_SEQ_PERIOD_CNT_EN, the port and its logic shall be absent and all other behaviour shall be identical.

Structure
REQ-032 Package pulse_seq_pkg shall hold the state enum (IDLE/RUN/DONE) and the address constants ADDR_PERIOD and ADDR_SLOT0.
REQ-033 Sub-module pulse_seq_slot shall hold one slot's compare/enable register and match decode, instantiated N_SLOT times via generate.

Verification
REQ-034 Bench shall cover continuous mode: defaults CNT_W=4; period=15, slot0=7 en, slot1=12 en, start oneshot=0 -> ctrl high exactly at cnt 7 and 12, repeating every 16 cycles, busy stays 1.
REQ-035 Bench shall cover oneshot mode: period=5, slot0=5 en, oneshot=1 -> ctrl at cnt 5, then DONE with done=1 for 1 cycle, then IDLE; total 7 cycles from start.
REQ-036 Bench shall cover abort: stop asserted at cnt=3, including a cycle with start and stop together -> IDLE next cycle, cnt=0, no done, no ctrl afterwards.
REQ-037 Bench shall cover config edges: write slot0=9 during RUN -> ignored; cmp=10 with period=8 -> never fires; cfg_addr=7 with N_SLOT=2 -> no effect.
REQ-038 Bench shall cover reset mid-run: rst_n low at cnt=6 -> all outputs 0 immediately, without waiting for clk; config returns to period=15 and slots disabled.
REQ-039 With PULSE_SEQ_PERIOD_CNT_EN, bench shall cover period counting: period=0 continuous for 70000 cycles -> period_cnt saturates at 0xFFFF.
